// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, instruction field positions
// and the fetch-stage state encoding.
package mips_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] JAL   = 6'h03;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    ERR
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] ins);
    return ins[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read handshake between the fetch stage and imem.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// Combinational next-PC select: jump target, taken branch target, or pc+4.
module next_pc_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [26:0]       instr_lo,
  input  logic              jump,
  input  logic              branch,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] branch_tgt;
  logic              taken;

  // instr[26] separates BNE from BEQ, so it flips the sense of the zero flag
  always_comb begin
    jump_tgt   = {pc_plus4[ADDR_W-1:28], instr_lo[25:0], 2'b00};
    branch_tgt = pc_plus4 + {{(ADDR_W-18){instr_lo[15]}}, instr_lo[15:0], 2'b00};
    taken      = branch & (alu_zero ^ instr_lo[26]);
    if (jump) begin
      next_pc = jump_tgt;
    end else if (taken) begin
      next_pc = branch_tgt;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, reads imem via req/ready, presents the instruction
// until exec_done, then advances to the decoder-selected next PC.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        imem,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [ADDR_W-1:0]    pc,
  output logic [ADDR_W-1:0]    pc_plus4,
  input  logic                 exec_done,
  input  logic                 jump,
  input  logic                 branch,
  input  logic                 alu_zero,
  output logic                 fetch_err
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_plus4_w;
  logic [ADDR_W-1:0] next_pc;

  assign pc_plus4_w = pc_q + ADDR_W'(4);

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_plus4 (pc_plus4_w),
    .instr_lo (instr_q[26:0]),
    .jump     (jump),
    .branch   (branch),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  // imem_req is registered, so it is raised on the transition into FETCH
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        req_d   = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          req_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (exec_done) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_w;
  assign fetch_err      = err_q;

endmodule
